frog_status: RTL and testbench

FROG_STATUS -- requirements
Module: frog_status

---
 rtl/frog_status.sv | 228 ++++++++++++++++++++++
 tb/tb_frog_status.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/frog_status.sv
// frog_status
//   Player status block for a two-player frog game: remaining lives per
//   player, a per-player ALIVE/DYING/DEAD grace FSM with respawn pulses,
//   the five-slot home occupancy bitmap and the registered stage-clear flag.
//
// Parameters
//   INIT_LIVES   lives loaded per player on startx (1..15)
//   GRACE_CYCLES death/respawn hold length in cycles (1..255)
//
// Ports
//   Clk, Reset          clock (rising edge), asynchronous active-high reset
//   startx              controller start state: reload lives, clear stage
//   stage1x, stage2x    controller is in stage 1 / stage 2
//   player2             two-player game active
//   winreset            stage-clear hold: clears homes/frogwins, keeps lives
//   hit1, hit2          collision pulses
//   home1, home2        home-reached pulses, with slot index slot1 / slot2
//   Life1, Life2        remaining lives
//   frogwins            all five home slots filled (registered)
//   homes               home slot occupancy bitmap
//   respawn1, respawn2  one-cycle pulse: frog re-placed at the start row
//
// Build option
//   FROG_BONUS_LIFE_EN  when defined, each non-DEAD player with 1..14 lives
//                       gains one life on the cycle frogwins rises.
module frog_status #(
   parameter int unsigned INIT_LIVES   = 3,
   parameter int unsigned GRACE_CYCLES = 16
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       startx,
   input  logic       stage1x,
   input  logic       stage2x,
   input  logic       player2,
   input  logic       winreset,
   input  logic       hit1,
   input  logic       hit2,
   input  logic       home1,
   input  logic       home2,
   input  logic [2:0] slot1,
   input  logic [2:0] slot2,
   output logic [3:0] Life1,
   output logic [3:0] Life2,
   output logic       frogwins,
   output logic [4:0] homes,
   output logic       respawn1,
   output logic       respawn2
);

   typedef enum logic [1:0] {
      ALIVE = 2'd0,
      DYING = 2'd1,
      DEAD  = 2'd2
   } pstate_e;

   typedef struct packed {
      pstate_e    st;
      logic [7:0] cnt;
      logic [3:0] life;
      logic       resp;
   } pnext_t;

   localparam logic [3:0] LIVES_INIT = 4'(INIT_LIVES);
   localparam logic [7:0] GRACE_LOAD = 8'(GRACE_CYCLES - 1);

   pstate_e    st1_q, st1_d, st2_q, st2_d;
   logic [7:0] cnt1_q, cnt1_d, cnt2_q, cnt2_d;
   logic [3:0] life1_q, life1_d, life2_q, life2_d;
   logic       resp1_q, resp1_d, resp2_q, resp2_d;
   logic [4:0] homes_q, homes_d;
   logic       frogwins_q, frogwins_d;

   logic       playing;
   logic       hit1_ev, hit2_ev;
   logic       home1_ok, home2_ok;
   logic [4:0] mask1, mask2;
   pnext_t     n1, n2;

   // One-hot slot decode; out-of-range slots yield an empty mask.
   function automatic logic [4:0] slot_mask(input logic [2:0] slot);
      logic [4:0] m;
      m = '0;
      if (slot <= 3'd4) m = 5'd1 << slot;
      return m;
   endfunction

   // Event-driven step of one player's FSM; startx/winreset overrides are
   // applied by the caller.
   function automatic pnext_t player_step(input pstate_e    st,
                                          input logic [7:0] cnt,
                                          input logic [3:0] life,
                                          input logic       hit_ev,
                                          input logic       home_ok);
      pnext_t n;
      n.st   = st;
      n.cnt  = cnt;
      n.life = life;
      n.resp = 1'b0;
      unique case (st)
         ALIVE: begin
            if (hit_ev && life != 4'd0) begin
               n.life = life - 4'd1;
               n.cnt  = GRACE_LOAD;
               n.st   = DYING;
            end else if (home_ok) begin
               n.resp = 1'b1;
            end
         end
         DYING: begin
            // The final death goes straight to DEAD with no respawn.
            if (cnt == 8'd0) begin
               n.resp = (life != 4'd0);
               n.st   = (life != 4'd0) ? ALIVE : DEAD;
            end else begin
               n.cnt = cnt - 8'd1;
            end
         end
         DEAD:    ;
         default: n.st = ALIVE;
      endcase
      return n;
   endfunction

   assign playing = (stage1x | stage2x) & ~winreset;
   assign mask1   = slot_mask(slot1);
   assign mask2   = slot_mask(slot2);

   // A same-cycle hit discards the home; both players homing to one slot
   // both see it free against the registered bitmap, so both respawn.
   assign hit1_ev  = playing & hit1;
   assign hit2_ev  = playing & player2 & hit2;
   assign home1_ok = playing & home1 & ~hit1 & (st1_q == ALIVE) &
                     (mask1 != 5'd0) & ((homes_q & mask1) == 5'd0);
   assign home2_ok = playing & player2 & home2 & ~hit2 & (st2_q == ALIVE) &
                     (mask2 != 5'd0) & ((homes_q & mask2) == 5'd0);

`ifdef FROG_BONUS_LIFE_EN
   logic bonus_rise;
   assign bonus_rise = ~frogwins_q & (&homes_q) & ~startx & ~winreset;
`endif

   always_comb begin
      n1 = player_step(st1_q, cnt1_q, life1_q, hit1_ev, home1_ok);
      n2 = player_step(st2_q, cnt2_q, life2_q, hit2_ev, home2_ok);

      st1_d   = n1.st;
      cnt1_d  = n1.cnt;
      life1_d = n1.life;
      resp1_d = n1.resp;
      st2_d   = n2.st;
      cnt2_d  = n2.cnt;
      life2_d = n2.life;
      resp2_d = n2.resp;

      homes_d    = homes_q | (home1_ok ? mask1 : 5'd0) | (home2_ok ? mask2 : 5'd0);
      frogwins_d = frogwins_q | (&homes_q);

`ifdef FROG_BONUS_LIFE_EN
      if (bonus_rise) begin
         if (st1_q != DEAD && life1_q != 4'd0 && life1_q != 4'd15 && life1_d != 4'd15)
            life1_d = life1_d + 4'd1;
         if (st2_q != DEAD && life2_q != 4'd0 && life2_q != 4'd15 && life2_d != 4'd15)
            life2_d = life2_d + 4'd1;
      end
`endif

      if (playing && !player2) life2_d = '0;

      if (startx) begin
         st1_d      = ALIVE;
         st2_d      = ALIVE;
         cnt1_d     = '0;
         cnt2_d     = '0;
         life1_d    = LIVES_INIT;
         life2_d    = LIVES_INIT;
         resp1_d    = 1'b0;
         resp2_d    = 1'b0;
         homes_d    = '0;
         frogwins_d = 1'b0;
      end else if (winreset) begin
         if (st1_q != DEAD) st1_d = ALIVE;
         if (st2_q != DEAD) st2_d = ALIVE;
         cnt1_d     = '0;
         cnt2_d     = '0;
         life1_d    = life1_q;
         life2_d    = life2_q;
         resp1_d    = 1'b0;
         resp2_d    = 1'b0;
         homes_d    = '0;
         frogwins_d = 1'b0;
      end
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         st1_q      <= ALIVE;
         st2_q      <= ALIVE;
         cnt1_q     <= '0;
         cnt2_q     <= '0;
         life1_q    <= '0;
         life2_q    <= '0;
         resp1_q    <= 1'b0;
         resp2_q    <= 1'b0;
         homes_q    <= '0;
         frogwins_q <= 1'b0;
      end else begin
         st1_q      <= st1_d;
         st2_q      <= st2_d;
         cnt1_q     <= cnt1_d;
         cnt2_q     <= cnt2_d;
         life1_q    <= life1_d;
         life2_q    <= life2_d;
         resp1_q    <= resp1_d;
         resp2_q    <= resp2_d;
         homes_q    <= homes_d;
         frogwins_q <= frogwins_d;
      end
   end

   assign Life1    = life1_q;
   assign Life2    = life2_q;
   assign frogwins = frogwins_q;
   assign homes    = homes_q;
   assign respawn1 = resp1_q;
   assign respawn2 = resp2_q;

endmodule

// File: tb/tb_frog_status.sv
module tb_frog_status;

   logic       Clk;
   logic       Reset;
   logic       startx, stage1x, stage2x, player2, winreset;
   logic       hit1, hit2, home1, home2;
   logic [2:0] slot1, slot2;
   logic [3:0] Life1, Life2;
   logic       frogwins;
   logic [4:0] homes;
   logic       respawn1, respawn2;

`ifdef FROG_BONUS_LIFE_EN
   localparam int BON = 1;
`else
   localparam int BON = 0;
`endif

   frog_status #(.INIT_LIVES(3), .GRACE_CYCLES(16)) dut (
      .Clk(Clk), .Reset(Reset), .startx(startx), .stage1x(stage1x),
      .stage2x(stage2x), .player2(player2), .winreset(winreset),
      .hit1(hit1), .hit2(hit2), .home1(home1), .home2(home2),
      .slot1(slot1), .slot2(slot2), .Life1(Life1), .Life2(Life2),
      .frogwins(frogwins), .homes(homes), .respawn1(respawn1),
      .respawn2(respawn2)
   );

   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   initial begin
      #400000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   int checks   = 0;
   int failures = 0;

   typedef struct {
      string      name;
      logic       stx, s1, s2, wr, p2, h1, h2, m1, m2;
      logic [2:0] sl1, sl2;
      logic [3:0] el1, el2;
      logic [4:0] eh;
      logic       efw, er1, er2;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input string nm,
                      input logic stx, s1, s2, wr, p2, h1, h2, m1, m2,
                      input logic [2:0] sl1, sl2,
                      input logic [3:0] el1, el2,
                      input logic [4:0] eh,
                      input logic efw, er1, er2);
      vec_t v;
      v.name = nm; v.stx = stx; v.s1 = s1; v.s2 = s2; v.wr = wr; v.p2 = p2;
      v.h1 = h1; v.h2 = h2; v.m1 = m1; v.m2 = m2; v.sl1 = sl1; v.sl2 = sl2;
      v.el1 = el1; v.el2 = el2; v.eh = eh; v.efw = efw; v.er1 = er1; v.er2 = er2;
      vecs.push_back(v);
   endtask

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic clear_events();
      startx = 0; winreset = 0; hit1 = 0; hit2 = 0; home1 = 0; home2 = 0;
      slot1 = 0; slot2 = 0;
   endtask

   // Hit player 1 while ALIVE, then watch the grace window for the respawn.
   task automatic hit_and_wait(input logic exp_resp, input logic [3:0] exp_life);
      hit1 = 1; tick(); hit1 = 0;
      chk("hit_life", 8'(Life1), 8'(exp_life));
      for (int k = 1; k <= 17; k++) begin
         tick();
         chk($sformatf("death_resp_k%0d", k), 8'(respawn1), 8'((exp_resp && k == 16) ? 1 : 0));
      end
   endtask

   initial begin
      logic [3:0] lb;
      logic [3:0] exp_l;
      lb = 4'(3 + BON);

      Reset = 1; stage1x = 0; stage2x = 0; player2 = 0;
      clear_events();
      tick(); tick();
      chk("rst_life1", 8'(Life1), 8'd0);
      chk("rst_life2", 8'(Life2), 8'd0);
      chk("rst_homes", 8'(homes), 8'd0);
      chk("rst_fw",    8'(frogwins), 8'd0);
      chk("rst_resp",  8'({respawn1, respawn2}), 8'd0);
      Reset = 0;

      //   name          stx s1 s2 wr p2 h1 h2 m1 m2 sl1 sl2 L1 L2  homes  fw r1 r2
      add("start",        1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 3, 5'b00000, 0, 0, 0);
      add("home_s0",      0, 1, 0, 0, 1, 0, 0, 1, 0, 0, 0, 3, 3, 5'b00001, 0, 1, 0);
      add("idle",         0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 3, 3, 5'b00001, 0, 0, 0);
      add("two_slots",    0, 0, 1, 0, 1, 0, 0, 1, 1, 1, 3, 3, 3, 5'b01011, 0, 1, 1);
      add("repeat_s1",    0, 0, 1, 0, 1, 0, 0, 1, 0, 1, 0, 3, 3, 5'b01011, 0, 0, 0);
      add("slot6",        0, 1, 0, 0, 1, 0, 0, 1, 0, 6, 0, 3, 3, 5'b01011, 0, 0, 0);
      add("not_playing",  0, 0, 0, 0, 1, 0, 0, 1, 0, 2, 0, 3, 3, 5'b01011, 0, 0, 0);
      add("winreset",     0, 1, 0, 1, 1, 0, 0, 1, 0, 2, 0, 3, 3, 5'b00000, 0, 0, 0);
      add("same_s3",      0, 1, 0, 0, 1, 0, 0, 1, 1, 3, 3, 3, 3, 5'b01000, 0, 1, 1);
      add("p2_off",       0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0, 5'b01000, 0, 0, 0);
      add("p2_home_ign",  0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 3, 0, 5'b01000, 0, 0, 0);
      add("fill_s0",      0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 3, 0, 5'b01001, 0, 1, 0);
      add("fill_s2",      0, 1, 0, 0, 0, 0, 0, 1, 0, 2, 0, 3, 0, 5'b01101, 0, 1, 0);
      add("fill_s4",      0, 1, 0, 0, 0, 0, 0, 1, 0, 4, 0, 3, 0, 5'b11101, 0, 1, 0);
      add("rep_s2",       0, 1, 0, 0, 0, 0, 0, 1, 0, 2, 0, 3, 0, 5'b11101, 0, 0, 0);
      add("fill_s1",      0, 1, 0, 0, 0, 0, 0, 1, 0, 1, 0, 3, 0, 5'b11111, 0, 1, 0);
      add("win_rise",     0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, lb, 0, 5'b11111, 1, 0, 0);
      add("win_hold",     0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, lb, 0, 5'b11111, 1, 0, 0);
      add("win_clear",    0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, lb, 0, 5'b00000, 0, 0, 0);
      add("start_and_wr", 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 3, 3, 5'b00000, 0, 0, 0);

      for (int i = 0; i < vecs.size(); i++) begin
         vec_t v;
         v = vecs[i];
         startx = v.stx; stage1x = v.s1; stage2x = v.s2; winreset = v.wr;
         player2 = v.p2; hit1 = v.h1; hit2 = v.h2; home1 = v.m1; home2 = v.m2;
         slot1 = v.sl1; slot2 = v.sl2;
         tick();
         chk({v.name, ".life1"}, 8'(Life1), 8'(v.el1));
         chk({v.name, ".life2"}, 8'(Life2), 8'(v.el2));
         chk({v.name, ".homes"}, 8'(homes), 8'(v.eh));
         chk({v.name, ".fw"},    8'(frogwins), 8'(v.efw));
         chk({v.name, ".r1"},    8'(respawn1), 8'(v.er1));
         chk({v.name, ".r2"},    8'(respawn2), 8'(v.er2));
      end
      clear_events();

      // Hit and home in the same cycle; second hit and a home during grace.
      stage1x = 1; stage2x = 0; player2 = 0;
      hit1 = 1; home1 = 1; slot1 = 0;
      tick();
      hit1 = 0; home1 = 0;
      chk("hit_home.life1", 8'(Life1), 8'd2);
      chk("hit_home.homes", 8'(homes), 8'd0);
      chk("hit_home.r1",    8'(respawn1), 8'd0);
      for (int k = 1; k <= 17; k++) begin
         hit1  = (k == 5);
         home1 = (k == 8);
         slot1 = 3'd0;
         tick();
         chk($sformatf("grace_resp_k%0d", k), 8'(respawn1), 8'((k == 16) ? 1 : 0));
      end
      hit1 = 0; home1 = 0;
      chk("grace.life1", 8'(Life1), 8'd2);
      chk("grace.homes", 8'(homes), 8'd0);

      // Remaining deaths: respawn on the first, none on the last.
      hit_and_wait(1'b1, 4'd1);
      hit_and_wait(1'b0, 4'd0);
      hit1 = 1; tick(); hit1 = 0;
      chk("dead_hit.life1", 8'(Life1), 8'd0);
      home1 = 1; slot1 = 2; tick(); home1 = 0;
      chk("dead_home.homes", 8'(homes), 8'd0);
      chk("dead_home.r1",    8'(respawn1), 8'd0);
      winreset = 1; tick(); winreset = 0;
      home1 = 1; slot1 = 2; tick(); home1 = 0;
      chk("dead_after_wr.homes", 8'(homes), 8'd0);
      stage1x = 0; startx = 1; tick(); startx = 0;
      chk("restart.life1", 8'(Life1), 8'd3);
      chk("restart.life2", 8'(Life2), 8'd3);

      // winreset mid-DYING returns to ALIVE with no pending respawn.
      stage1x = 1;
      hit1 = 1; tick(); hit1 = 0;
      chk("wr_dying.life1", 8'(Life1), 8'd2);
      tick(); tick(); tick();
      winreset = 1; tick(); winreset = 0;
      for (int k = 0; k < 20; k++) begin
         tick();
         chk($sformatf("wr_dying_resp_k%0d", k), 8'(respawn1), 8'd0);
      end
      hit1 = 1; tick(); hit1 = 0;
      chk("wr_dying_alive.life1", 8'(Life1), 8'd1);

      // Asynchronous reset mid-DYING aborts the death.
      tick(); tick(); tick(); tick();
      #2 Reset = 1;
      #1;
      chk("rst_dying.life1", 8'(Life1), 8'd0);
      chk("rst_dying.r1",    8'(respawn1), 8'd0);
      chk("rst_dying.homes", 8'(homes), 8'd0);
      #1 Reset = 0;
      for (int k = 0; k < 20; k++) begin
         tick();
         chk($sformatf("rst_dying_resp_k%0d", k), 8'(respawn1), 8'd0);
      end

      // Repeated stage clears: bonus lives saturate at 15 when enabled.
      stage1x = 0; startx = 1; tick(); startx = 0;
      chk("bonus_start.life1", 8'(Life1), 8'd3);
      stage1x = 1; player2 = 1;
      for (int clr = 1; clr <= 13; clr++) begin
         for (int s = 0; s < 5; s++) begin
            home1 = 1; slot1 = 3'(s);
            tick();
         end
         home1 = 0;
         tick();
         exp_l = (BON == 1) ? ((3 + clr > 15) ? 4'd15 : 4'(3 + clr)) : 4'd3;
         chk($sformatf("clr%0d.fw", clr),    8'(frogwins), 8'd1);
         chk($sformatf("clr%0d.life1", clr), 8'(Life1), 8'(exp_l));
         chk($sformatf("clr%0d.life2", clr), 8'(Life2), 8'(exp_l));
         winreset = 1; tick(); winreset = 0;
         chk($sformatf("clr%0d.wr_homes", clr), 8'(homes), 8'd0);
         chk($sformatf("clr%0d.wr_fw", clr),    8'(frogwins), 8'd0);
         chk($sformatf("clr%0d.wr_life1", clr), 8'(Life1), 8'(exp_l));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
